// File: rtl/div_32_bit_seq_if.sv
// Operand/result bundle for the sequential signed divider.
// The requester drives start and the operands; the divider drives results and status.
interface div_32_bit_seq_if;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, Ra, Rb,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, Ra, Rb,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_32_bit_seq.sv
// 32-bit signed sequential divider: one non-restoring step per clock on operand magnitudes,
// followed by a sign/remainder fix-up cycle. Truncates toward zero; remainder follows the dividend.
//
// state | meaning
// IDLE  | waiting for start; results held
// ITER  | one non-restoring step per edge, 32 steps
// FIX   | remainder correction, sign fix-up, result load (also loads the divide-by-zero result)
// DONE  | one-cycle done pulse, returns to IDLE
module div_32_bit_seq (
    input logic             clock,
    input logic             clear,
    div_32_bit_seq_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  step;
    logic [32:0] prem;
    logic [31:0] quo_work;
    logic [31:0] dvs_mag;
    logic [31:0] dvd_raw;
    logic        neg_quo;
    logic        neg_rem;
    logic        zero_div;
    logic [31:0] quo_reg;
    logic [31:0] rem_reg;
    logic        dbz_reg;

    logic [32:0] prem_shift;
    logic [32:0] prem_step;
    logic [32:0] rem_fix;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.Rb == 32'd0) ? FIX : ITER;
            ITER: if (step == 6'd31) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // 33-bit arithmetic; any carry beyond bit 32 is dropped by the width.
    always_comb begin
        prem_shift = {prem[31:0], quo_work[31]};
        prem_step  = prem[32] ? (prem_shift + {1'b0, dvs_mag})
                              : (prem_shift - {1'b0, dvs_mag});
        rem_fix    = prem[32] ? (prem + {1'b0, dvs_mag}) : prem;
        quo_final  = neg_quo ? (32'd0 - quo_work) : quo_work;
        rem_final  = neg_rem ? (32'd0 - rem_fix[31:0]) : rem_fix[31:0];
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            step     <= 6'd0;
            prem     <= 33'd0;
            quo_work <= 32'd0;
            dvs_mag  <= 32'd0;
            dvd_raw  <= 32'd0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            quo_reg  <= 32'd0;
            rem_reg  <= 32'd0;
            dbz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        step     <= 6'd0;
                        prem     <= 33'd0;
                        quo_work <= bus.Ra[31] ? (32'd0 - bus.Ra) : bus.Ra;
                        dvs_mag  <= bus.Rb[31] ? (32'd0 - bus.Rb) : bus.Rb;
                        dvd_raw  <= bus.Ra;
                        neg_quo  <= bus.Ra[31] ^ bus.Rb[31];
                        neg_rem  <= bus.Ra[31];
                        zero_div <= (bus.Rb == 32'd0);
                    end
                end
                ITER: begin
                    prem     <= prem_step;
                    quo_work <= {quo_work[30:0], ~prem_step[32]};
                    step     <= step + 6'd1;
                end
                FIX: begin
                    if (zero_div) begin
                        quo_reg <= 32'hFFFF_FFFF;
                        rem_reg <= dvd_raw;
                        dbz_reg <= 1'b1;
                    end else begin
                        quo_reg <= quo_final;
                        rem_reg <= rem_final;
                        dbz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;

endmodule
